rsp_pkt_arb: RTL and testbench

// - Packet-aware round-robin arbiter that shares the single NOC response port among the NSRC

---
 rtl/rsp_pkt_arb.sv | 146 ++++++++++++++
 tb/tb_rsp_pkt_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsp_pkt_arb.sv
`default_nettype none
// rsp_pkt_arb: packet-aware round-robin arbiter sharing the NOC response port among NSRC
// show-ahead p2n FIFOs; a grant is held for a whole packet and released on its last word.
module rsp_pkt_arb #(
  parameter int NSRC = 4,
  parameter int DW   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*(DW+1)-1:0] src_word,
  input  logic [NSRC-1:0]        src_empty,
  output logic [NSRC-1:0]        src_pop,
  output logic                   noc_from_dev_ctl,
  output logic [DW-1:0]          noc_from_dev_data,
  output logic [NSRC-1:0]        grant,
  output logic                   busy,
  output logic                   hdr_err,
  output logic                   underrun
);
  localparam int PW = $clog2(NSRC);
  localparam logic [2:0] OP_WR  = 3'b100;
  localparam logic [2:0] OP_MSG = 3'b101;
  localparam logic [2:0] OP_RD  = 3'b011;

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [8:0]    rem;
  logic          len_phase;

  logic [DW:0]   words [NSRC];

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_words
    assign words[gi] = src_word[gi*(DW+1) +: DW+1];
  end

  // Round-robin scan starting just after the last packet owner.
  logic          found;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= NSRC; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NSRC);
      if (!found && !src_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  logic [PW-1:0] sel;
  logic [DW:0]   head;
  logic          pop_any;
  logic          is_hdr;
  logic          fwd;
  logic [8:0]    hdr_len;
  logic [8:0]    len_val;
  logic          hdr_rd;
  logic          hdr_bad;
  logic          last_pop;
  always_comb begin
    sel     = (state == IDLE) ? pick : owner;
    head    = words[sel];
    pop_any = !reset && ((state == IDLE) ? found : !src_empty[owner]);
    is_hdr  = head[DW] && (head[DW-1:0] != '0);
    // Junk words popped while idle are dropped, not forwarded.
    fwd     = pop_any && ((state == XFER) || is_hdr);
    src_pop = pop_any ? (NSRC'(1) << sel) : '0;
    hdr_len = 9'd0;
    hdr_rd  = 1'b0;
    hdr_bad = 1'b0;
    case (head[2:0])
      OP_WR:   hdr_len = 9'd4;
      OP_MSG:  hdr_len = 9'd5;
      OP_RD: begin
        hdr_len = 9'd2;
        hdr_rd  = 1'b1;
      end
      default: hdr_bad = 1'b1;
    endcase
    len_val  = 9'(head[DW-1:0]);
    last_pop = (len_phase && rem == 9'd1) ? (len_val == 9'd0) : (rem == 9'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      rr_ptr            <= PW'(NSRC - 1);
      owner             <= '0;
      rem               <= '0;
      len_phase         <= 1'b0;
      noc_from_dev_ctl  <= 1'b1;
      noc_from_dev_data <= '0;
      grant             <= '0;
      busy              <= 1'b0;
      hdr_err           <= 1'b0;
      underrun          <= 1'b0;
    end else begin
      hdr_err           <= 1'b0;
      underrun          <= 1'b0;
      noc_from_dev_ctl  <= fwd ? head[DW] : 1'b1;
      noc_from_dev_data <= fwd ? head[DW-1:0] : '0;
      case (state)
        IDLE: begin
          // grant/busy stay aligned with the output word, so they clear one cycle after XFER ends.
          grant <= '0;
          busy  <= 1'b0;
          if (pop_any) begin
            if (!is_hdr || hdr_bad) hdr_err <= 1'b1;
            if (is_hdr) begin
              rr_ptr <= pick;
              if (!hdr_bad) begin
                state     <= XFER;
                owner     <= pick;
                grant     <= src_pop;
                busy      <= 1'b1;
                rem       <= hdr_len;
                len_phase <= hdr_rd;
              end
            end
          end
        end
        XFER: begin
          if (!pop_any) begin
            underrun <= 1'b1;
          end else begin
            if (len_phase && rem == 9'd1) begin
              rem       <= len_val;
              len_phase <= 1'b0;
            end else begin
              rem <= rem - 9'd1;
            end
            if (last_pop) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rsp_pkt_arb.sv
`default_nettype none
// Bench for rsp_pkt_arb: show-ahead FIFO model fed by directed packets; a monitor pops the
// scoreboard for every non-idle output word and checks word, grant and zero-gap timing.
module tb_rsp_pkt_arb;
  localparam int NSRC = 4;
  localparam int DW   = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NSRC*(DW+1)-1:0] src_word;
  logic [NSRC-1:0]        src_empty;
  logic [NSRC-1:0]        src_pop;
  logic                   ctl;
  logic [DW-1:0]          data;
  logic [NSRC-1:0]        grant;
  logic                   busy;
  logic                   hdr_err;
  logic                   underrun;

  rsp_pkt_arb #(.NSRC(NSRC), .DW(DW)) dut (
    .clk               (clk),
    .reset             (reset),
    .src_word          (src_word),
    .src_empty         (src_empty),
    .src_pop           (src_pop),
    .noc_from_dev_ctl  (ctl),
    .noc_from_dev_data (data),
    .grant             (grant),
    .busy              (busy),
    .hdr_err           (hdr_err),
    .underrun          (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] w;
    logic [3:0] g;
    logic       contig;
  } exp_t;

  exp_t            sb[$];
  logic [8:0]      fifo[NSRC][$];
  logic [NSRC-1:0] pend_pop;
  int n_checks = 0;
  int n_pass   = 0;
  int herr_cnt = 0;
  int ur_cnt   = 0;
  int cyc      = 0;
  int last_cyc = -10;

  task automatic check(input string name, input logic ok, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic refresh();
    for (int i = 0; i < NSRC; i++) begin
      src_empty[i] = (fifo[i].size() == 0);
      src_word[i*(DW+1) +: DW+1] = (fifo[i].size() == 0) ? 9'h000 : fifo[i][0];
    end
  endtask

  function automatic logic fifos_busy();
    logic r = 1'b0;
    for (int i = 0; i < NSRC; i++) if (fifo[i].size() != 0) r = 1'b1;
    return r;
  endfunction

  // One clock: apply last cycle's pops, present new heads, then sample the pop decision.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < NSRC; i++)
      if (pend_pop[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    refresh();
    #3;
    pend_pop = src_pop;
  endtask

  task automatic push(input int s, input logic [8:0] w);
    fifo[s].push_back(w);
  endtask

  task automatic expect_w(input logic [8:0] w, input logic [3:0] g, input logic c);
    exp_t e;
    e.w = w;
    e.g = g;
    e.contig = c;
    sb.push_back(e);
  endtask

  task automatic run_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy || fifos_busy()) && n < 80) begin
      cycle();
      n++;
    end
    check({name, " completion cycles"}, n < 80, n, 80);
    repeat (3) cycle();
    check({name, " scoreboard drained"}, sb.size() == 0, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!reset) begin
      if (hdr_err) herr_cnt = herr_cnt + 1;
      if (underrun) ur_cnt = ur_cnt + 1;
      if ({ctl, data} != 9'h100) begin
        check("word expected", sb.size() != 0, int'({ctl, data}), 'h100);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out word", {ctl, data} == e.w, int'({ctl, data}), int'(e.w));
          check("out grant", grant == e.g, int'(grant), int'(e.g));
          if (e.contig) check("zero gap", cyc == last_cyc + 1, cyc - last_cyc, 1);
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    int hb;
    int ub;
    int srcs[3];
    srcs = '{0, 1, 3};
    src_word  = '0;
    src_empty = '1;
    pend_pop  = '0;
    repeat (2) cycle();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("idle out", {grant, busy, ctl, data} == 14'h0100 && src_pop == '0,
            int'({grant, busy, ctl, data}), 'h100);
    end

    // WR_RSP on src1
    hb = herr_cnt;
    push(1, 9'h104);
    expect_w(9'h104, 4'b0010, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      push(1, 9'(i * 17));
      expect_w(9'(i * 17), 4'b0010, 1'b1);
    end
    run_done("wr");
    check("wr hdr_err", herr_cnt == hb, herr_cnt - hb, 0);

    // RD_RSP len 3 then len 0 back-to-back on src2
    push(2, 9'h103); expect_w(9'h103, 4'b0100, 1'b0);
    push(2, 9'h040); expect_w(9'h040, 4'b0100, 1'b1);
    push(2, 9'h003); expect_w(9'h003, 4'b0100, 1'b1);
    push(2, 9'h0a1); expect_w(9'h0a1, 4'b0100, 1'b1);
    push(2, 9'h0a2); expect_w(9'h0a2, 4'b0100, 1'b1);
    push(2, 9'h0a3); expect_w(9'h0a3, 4'b0100, 1'b1);
    push(2, 9'h103); expect_w(9'h103, 4'b0100, 1'b1);
    push(2, 9'h040); expect_w(9'h040, 4'b0100, 1'b1);
    push(2, 9'h000); expect_w(9'h000, 4'b0100, 1'b1);
    run_done("rd");

    // Reset mid-packet: header forwarded, rest abandoned
    push(1, 9'h104);
    for (int i = 1; i <= 4; i++) push(1, 9'(i * 17));
    expect_w(9'h104, 4'b0010, 1'b0);
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    check("reset mid-packet", {grant, busy, ctl, data} == 14'h0100 && src_pop == '0,
          int'({grant, busy, ctl, data}), 'h100);
    for (int i = 0; i < NSRC; i++) fifo[i].delete();
    pend_pop = '0;
    refresh();
    cycle();
    cycle();
    reset = 1'b0;
    run_done("reset");

    // MSG on src0, src1, src3 simultaneously
    for (int k = 0; k < 3; k++) begin
      push(srcs[k], 9'h105);
      expect_w(9'h105, 4'(1 << srcs[k]), k != 0);
      for (int j = 1; j <= 5; j++) begin
        push(srcs[k], 9'(srcs[k] * 16 + j));
        expect_w(9'(srcs[k] * 16 + j), 4'(1 << srcs[k]), 1'b1);
      end
    end
    run_done("msg rr");

    // Starvation: two words missing for four cycles
    ub = ur_cnt;
    push(0, 9'h104); expect_w(9'h104, 4'b0001, 1'b0);
    push(0, 9'h0b1); expect_w(9'h0b1, 4'b0001, 1'b1);
    push(0, 9'h0b2); expect_w(9'h0b2, 4'b0001, 1'b1);
    repeat (5) cycle();
    check("grant held in underrun", grant == 4'b0001 && busy, int'({grant, busy}), 'h3);
    repeat (2) cycle();
    push(0, 9'h0b3); expect_w(9'h0b3, 4'b0001, 1'b0);
    push(0, 9'h0b4); expect_w(9'h0b4, 4'b0001, 1'b1);
    run_done("underrun");
    check("underrun pulses", ur_cnt - ub == 4, ur_cnt - ub, 4);

    // Junk word then unknown opcode on src3
    hb = herr_cnt;
    push(3, 9'h055);
    push(3, 9'h107);
    expect_w(9'h107, 4'b0000, 1'b0);
    run_done("junk");
    check("hdr_err pulses", herr_cnt - hb == 2, herr_cnt - hb, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish, required finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
